// File: rtl/regfile_wr_if.sv
// Writeback bus between the requesters and the register-file write arbiter.
// Requester-side request/grant signals plus the registered WE3/A3/WD3 write port.
interface regfile_wr_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rf_we;
    logic [ADDR_W-1:0]         rf_addr;
    logic [DATA_W-1:0]         rf_wdata;
    logic                      init_busy;
    logic [IDX_W-1:0]          grant_id;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, rf_we, rf_addr, rf_wdata, init_busy, grant_id
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, rf_we, rf_addr, rf_wdata, init_busy, grant_id
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port among NUM_REQ writeback sources with
// round-robin valid/ready arbitration; clears every register once after reset.
module regfile_write_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic         clk,
    input  logic         reset,
    regfile_wr_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(NUM_REGS) + 1;
    localparam logic [CNT_W-1:0] LAST_CLR = CNT_W'(NUM_REGS - 1);
    localparam logic [IDX_W:0]   NREQ     = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    state_t              state_n;
    logic [CNT_W-1:0]    clr_cnt;
    logic [IDX_W-1:0]    rr_ptr;

    logic [NUM_REQ-1:0]  grant_p0;
    logic                acc_p0;
    logic [IDX_W-1:0]    gid_p0;
    logic [ADDR_W-1:0]   addr_p0;
    logic [DATA_W-1:0]   data_p0;

    logic                vld_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic [DATA_W-1:0]   wdata_p1;
    logic [IDX_W-1:0]    gid_p1;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                    input logic [IDX_W-1:0]   ptr);
        logic [NUM_REQ-1:0] gnt;
        logic [IDX_W:0]     pos;
        logic               found;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (pos >= NREQ) pos = pos - NREQ;
            if (!found && valid[pos[IDX_W-1:0]]) begin
                gnt[pos[IDX_W-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
        return (g == LAST_IDX) ? '0 : g + IDX_W'(1);
    endfunction

    // Stage p0: next state, grant and selected request (combinational)
    always_comb begin
        state_n  = state;
        grant_p0 = '0;
        case (state)
            INIT: begin
                if (clr_cnt == LAST_CLR) state_n = RUN;
            end
            RUN: begin
                if (!reset) grant_p0 = rr_pick(bus.req_valid, rr_ptr);
            end
            default: state_n = INIT;
        endcase
    end

    always_comb begin
        acc_p0  = |grant_p0;
        gid_p0  = onehot_idx(grant_p0);
        addr_p0 = '0;
        data_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_p0[i]) begin
                addr_p0 = bus.req_addr[i*ADDR_W +: ADDR_W];
                data_p0 = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= state_n;
    end

    // Stage p1: registered write port; x0 writes complete the handshake with WE low
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt  <= '0;
            rr_ptr   <= '0;
            vld_p1   <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
            gid_p1   <= '0;
        end else if (state == INIT) begin
            vld_p1   <= 1'b1;
            addr_p1  <= ADDR_W'(clr_cnt);
            wdata_p1 <= '0;
            clr_cnt  <= clr_cnt + CNT_W'(1);
        end else if (acc_p0) begin
            vld_p1   <= (addr_p0 != '0);
            addr_p1  <= addr_p0;
            wdata_p1 <= data_p0;
            gid_p1   <= gid_p0;
            rr_ptr   <= ptr_after(gid_p0);
        end else begin
            vld_p1   <= 1'b0;
        end
    end

    assign bus.req_ready = grant_p0;
    assign bus.rf_we     = vld_p1;
    assign bus.rf_addr   = addr_p1;
    assign bus.rf_wdata  = wdata_p1;
    assign bus.grant_id  = gid_p1;
    assign bus.init_busy = (state == INIT);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset/clear sequence, round-robin
// grants, x0 suppression, reset recovery and backpressure, checked by a scoreboard.
module tb_regfile_write_arbiter;
    localparam int NUM_REQ  = 3;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int IDX_W    = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_wr_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_write_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  gid;
    } exp_t;

    exp_t sb[$];
    exp_t m_last;
    int   m_ptr    = 0;
    int   n_chk    = 0;
    int   n_pass   = 0;
    int   cafe_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] a0, a1, a2,
                         input logic [31:0] d0, d1, d2);
        bus.req_valid = v;
        bus.req_addr  = {a2, a1, a0};
        bus.req_data  = {d2, d1, d0};
    endtask

    // Holds reset for n edges with all requesters asserting, then releases it.
    task automatic reset_seq(input string tag, input int n);
        reset = 1'b1;
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
        #1;
        chk({tag, ".rdy_in_reset"}, bus.req_ready, 3'b000);
        for (int i = 0; i < n; i++) tick();
        chk({tag, ".rst_we"},    bus.rf_we,     1'b0);
        chk({tag, ".rst_addr"},  bus.rf_addr,   5'd0);
        chk({tag, ".rst_wdata"}, bus.rf_wdata,  32'd0);
        chk({tag, ".rst_gid"},   bus.grant_id,  2'd0);
        chk({tag, ".rst_busy"},  bus.init_busy, 1'b1);
        chk({tag, ".rst_rdy"},   bus.req_ready, 3'b000);
        m_ptr = 0;
        sb.delete();
        m_last = '0;
        reset  = 1'b0;
    endtask

    // Observes n cycles of the clear sequence while requesters keep asking.
    task automatic run_init(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (i == NUM_REGS - 1) bus.req_valid = 3'b000;
            else                   bus.req_valid = 3'b111;
            tick();
            chk({tag, ".clr_we"},    bus.rf_we,     1'b1);
            chk({tag, ".clr_addr"},  bus.rf_addr,   64'(i));
            chk({tag, ".clr_wdata"}, bus.rf_wdata,  32'd0);
            chk({tag, ".clr_busy"},  bus.init_busy, (i != NUM_REGS - 1));
            if (i < NUM_REGS - 1) chk({tag, ".clr_rdy"}, bus.req_ready, 3'b000);
        end
        if (n == NUM_REGS) begin
            m_last      = '0;
            m_last.addr = 5'(NUM_REGS - 1);
        end
    endtask

    // One arbitration cycle: predict the grant, queue the expected write, check it a cycle later.
    task automatic cycle(input string tag, input logic [2:0] v, input logic [4:0] a0, a1, a2,
                         input logic [31:0] d0, d1, d2);
        int               g;
        exp_t             e;
        logic [2:0]       exp_rdy;
        logic [4:0]       aa [3];
        logic [31:0]      dd [3];
        aa[0] = a0; aa[1] = a1; aa[2] = a2;
        dd[0] = d0; dd[1] = d1; dd[2] = d2;
        drive(v, a0, a1, a2, d0, d1, d2);
        #1;
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (g < 0 && ((v >> idx) & 3'b001) != 3'b000) g = idx;
        end
        exp_rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
        chk({tag, ".ready"}, bus.req_ready, exp_rdy);
        if (g >= 0) begin
            e.we   = (aa[g] != 5'd0);
            e.addr = aa[g];
            e.data = dd[g];
            e.gid  = g[IDX_W-1:0];
            m_ptr  = (g + 1) % NUM_REQ;
        end else begin
            e    = m_last;
            e.we = 1'b0;
        end
        m_last = e;
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        chk({tag, ".we"},    bus.rf_we,    e.we);
        chk({tag, ".addr"},  bus.rf_addr,  e.addr);
        chk({tag, ".wdata"}, bus.rf_wdata, e.data);
        chk({tag, ".gid"},   bus.grant_id, e.gid);
        if (bus.rf_we && bus.rf_wdata == 32'hCAFE0002) cafe_cnt++;
    endtask

    initial begin
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        // T1: reset release and full clear sequence
        reset_seq("T1", 2);
        run_init("T1", NUM_REGS);
        cycle("T1.idle", 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        // T3: all requesters valid, grants rotate 0,1,2,0,1,2
        for (int i = 0; i < 6; i++)
            cycle("T3", 3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3);
        chk("T3.gid_last", bus.grant_id, 2'd2);

        // T2: single requester 1
        cycle("T2", 3'b010, 5'd0, 5'd5, 5'd0, 32'd0, 32'hDEADBEEF, 32'd0);
        chk("T2.gid", bus.grant_id, 2'd1);

        // T4: write to x0 suppresses WE but still advances the pointer
        cycle("T4.x0", 3'b001, 5'd0, 5'd0, 5'd0, 32'h1234, 32'd0, 32'd0);
        chk("T4.x0_we", bus.rf_we, 1'b0);
        cycle("T4.next", 3'b011, 5'd8, 5'd9, 5'd0, 32'h80, 32'h90, 32'd0);
        chk("T4.next_gid", bus.grant_id, 2'd1);

        // T6: requester 2 waits behind 0 and 1 with its request held
        cycle("T6.a", 3'b100, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'h77);
        cycle("T6.b", 3'b111, 5'd4, 5'd6, 5'd9, 32'h44, 32'h66, 32'hCAFE0002);
        cycle("T6.c", 3'b110, 5'd4, 5'd6, 5'd9, 32'h44, 32'h66, 32'hCAFE0002);
        cycle("T6.d", 3'b100, 5'd4, 5'd6, 5'd9, 32'h44, 32'h66, 32'hCAFE0002);
        cycle("T6.e", 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        chk("T6.single_write", 64'(cafe_cnt), 64'd1);

        // T5: reset in the middle of the clear sequence
        reset_seq("T5a", 1);
        run_init("T5a", 11);
        reset_seq("T5b", 1);
        run_init("T5b", NUM_REGS);

        // T5: reset while streaming; pointer restarts at requester 0
        cycle("T5.s0", 3'b111, 5'd1, 5'd2, 5'd3, 32'hB1, 32'hB2, 32'hB3);
        cycle("T5.s1", 3'b111, 5'd1, 5'd2, 5'd3, 32'hB1, 32'hB2, 32'hB3);
        reset_seq("T5c", 1);
        run_init("T5c", NUM_REGS);
        cycle("T5.rr", 3'b111, 5'd1, 5'd2, 5'd3, 32'hC1, 32'hC2, 32'hC3);
        chk("T5.rr_gid", bus.grant_id, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
